snake_move_controller: RTL and testbench

- Sequences the snake body-position memory once per game tick: computes the new head, checks wall/self collision and apple capture, shifts the body, writes the head, tracks size and issues win/loss.
- Sits between the movement-period timer and button/direction decoder on one side and the body RAM, apple generator and LED renderer on the other.
- Grid is 6x6; a position is {row[2:0], col[2:0]}, valid rows and columns 0..5.

---
 rtl/snake_move_controller.sv | 272 +++++++++++++++++++++++++++
 tb/tb_snake_move_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_controller.sv
// Snake move sequencer: per tick computes the new head, checks wall/self hits, shifts the body RAM and writes the head.
// Latency: at most 3*MAX_SIZE+4 busy cycles from tick to the head write; INIT takes 2 cycles after start.
// Backpressure: none; tick is dropped while busy or paused, start is honoured only in IDLE/WON/LOST.
module snake_move_controller #(
   parameter int unsigned MAX_SIZE  = 8,
   parameter int unsigned INIT_SIZE = 2
) (
   input  logic       clock,
   input  logic       restart_n,
   input  logic       start,
   input  logic       pause,
   input  logic       tick,
   input  logic [1:0] dir,
   input  logic [5:0] apple_pos,
   input  logic [5:0] mem_rdata,
   output logic [3:0] mem_addr,
   output logic       mem_we,
   output logic [5:0] mem_wdata,
   output logic [3:0] size,
   output logic       eat,
   output logic       busy,
   output logic       won,
   output logic       lost,
   output logic       finished,
   output logic [4:0] db_state
);

   typedef enum logic [4:0] {
      ST_IDLE      = 5'd0,
      ST_INIT      = 5'd1,
      ST_WAIT_TICK = 5'd2,
      ST_PAUSED    = 5'd3,
      ST_CALC      = 5'd4,
      ST_CHECK     = 5'd5,
      ST_SHIFT     = 5'd6,
      ST_HEAD      = 5'd7,
      ST_WON       = 5'd8,
      ST_LOST      = 5'd9
   } state_e;

   // Shift sub-phases: PRE reads the top entry, RD reads ahead (or idles), WR writes one entry down.
   typedef enum logic [1:0] {
      PH_PRE = 2'd0,
      PH_RD  = 2'd1,
      PH_WR  = 2'd2
   } phase_e;

   localparam logic [3:0] MAX_SZ    = 4'(MAX_SIZE);
   localparam logic [3:0] INIT_SZ   = 4'(INIT_SIZE);
   localparam logic [5:0] POS_HEAD0 = 6'o22;
   localparam logic [5:0] POS_BODY0 = 6'o21;

   state_e     state_q, state_d;
   phase_e     ph_q, ph_d;
   logic [3:0] addr_q, addr_d;
   logic       we_q, we_d;
   logic [5:0] wdata_q, wdata_d;
   logic [3:0] size_q, size_d;
   logic       eat_q, eat_d;
   logic       busy_q, busy_d;
   logic       won_q, won_d;
   logic       lost_q, lost_d;
   logic       fin_q, fin_d;
   logic [5:0] nh_q, nh_d;
   logic       grow_q, grow_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rd_q, rd_d;
   logic       cap_q, cap_d;

   logic [2:0] nrow, ncol;
   logic       off_grid;
   logic [3:0] len;

   // Candidate head from the RAM head word and dir; 3-bit wrap of 0-1 lands on 7 and is caught as off-grid.
   always_comb begin
      nrow = mem_rdata[5:3];
      ncol = mem_rdata[2:0];
      case (dir)
         2'b00:   nrow = mem_rdata[5:3] - 3'd1;
         2'b01:   ncol = mem_rdata[2:0] + 3'd1;
         2'b10:   nrow = mem_rdata[5:3] + 3'd1;
         default: ncol = mem_rdata[2:0] - 3'd1;
      endcase
      off_grid = (nrow > 3'd5) || (ncol > 3'd5);
      // Entries checked and shifted: the tail only stays when the snake grows.
      len = grow_q ? size_q : size_q - 4'd1;
   end

   // Next-state and next-output decode. Shift is pipelined so each entry costs two cycles:
   // reads run one step ahead of writes and the read data is parked in wdata_q (cap_q marks a valid read).
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = cap_q ? mem_rdata : wdata_q;
      size_d  = size_q;
      eat_d   = 1'b0;
      nh_d    = nh_q;
      grow_d  = grow_q;
      cnt_d   = cnt_q;
      rd_d    = 1'b0;
      cap_d   = rd_q;
      case (state_q)
         ST_IDLE, ST_WON, ST_LOST: begin
            if (start) begin
               state_d = ST_INIT;
               addr_d  = 4'd0;
               we_d    = 1'b1;
               wdata_d = POS_HEAD0;
               size_d  = 4'd0;
               cnt_d   = 4'd0;
            end
         end
         ST_INIT: begin
            if (cnt_q == 4'd0) begin
               addr_d  = 4'd1;
               we_d    = 1'b1;
               wdata_d = POS_BODY0;
               cnt_d   = 4'd1;
            end else begin
               state_d = ST_WAIT_TICK;
               size_d  = INIT_SZ;
               addr_d  = 4'd0;
            end
         end
         ST_WAIT_TICK: begin
            // addr stays 0 here so the head word is on mem_rdata during CALC
            if (pause) begin
               state_d = ST_PAUSED;
            end else if (tick) begin
               state_d = ST_CALC;
            end
         end
         ST_PAUSED: begin
            if (!pause) begin
               state_d = ST_WAIT_TICK;
            end
         end
         ST_CALC: begin
            if (off_grid) begin
               state_d = ST_LOST;
            end else begin
               nh_d    = {nrow, ncol};
               grow_d  = ({nrow, ncol} == apple_pos);
               state_d = ST_CHECK;
               addr_d  = 4'd0;
               cnt_d   = 4'd0;
            end
         end
         ST_CHECK: begin
            // cnt_q counts cycles; from cnt_q=1 on, mem_rdata holds body index cnt_q-1
            if ((cnt_q != 4'd0) && (mem_rdata == nh_q)) begin
               state_d = ST_LOST;
            end else if (cnt_q == len) begin
               state_d = ST_SHIFT;
               ph_d    = PH_PRE;
               addr_d  = len - 4'd1;
               rd_d    = 1'b1;
               cnt_d   = len;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if ((cnt_q + 4'd1) < len) begin
                  addr_d = cnt_q + 4'd1;
               end
            end
         end
         ST_SHIFT: begin
            // cnt_q is the index written by the next write cycle
            case (ph_q)
               PH_PRE: begin
                  ph_d = PH_RD;
                  if (cnt_q >= 4'd2) begin
                     addr_d = cnt_q - 4'd2;
                     rd_d   = 1'b1;
                  end
               end
               PH_RD: begin
                  ph_d   = PH_WR;
                  addr_d = cnt_q;
                  we_d   = 1'b1;
               end
               PH_WR: begin
                  if (cnt_q == 4'd1) begin
                     state_d = ST_HEAD;
                     addr_d  = 4'd0;
                     we_d    = 1'b1;
                     wdata_d = nh_q;
                     eat_d   = grow_q;
                     size_d  = size_q + {3'd0, grow_q};
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                     if (cnt_q >= 4'd3) begin
                        ph_d   = PH_RD;
                        addr_d = cnt_q - 4'd3;
                        rd_d   = 1'b1;
                     end else begin
                        ph_d   = PH_WR;
                        addr_d = 4'd1;
                        we_d   = 1'b1;
                     end
                  end
               end
               default: ph_d = PH_PRE;
            endcase
         end
         ST_HEAD: begin
            if (size_q == MAX_SZ) begin
               state_d = ST_WON;
            end else begin
               state_d = ST_WAIT_TICK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = !(state_d inside {ST_WAIT_TICK, ST_PAUSED, ST_IDLE, ST_WON, ST_LOST});
      won_d  = (state_d == ST_WON);
      lost_d = (state_d == ST_LOST);
      fin_d  = won_d | lost_d;
   end

   // State and registered outputs, synchronous active-low restart.
   always_ff @(posedge clock) begin
      if (!restart_n) begin
         state_q <= ST_IDLE;
         ph_q    <= PH_PRE;
         addr_q  <= 4'd0;
         we_q    <= 1'b0;
         wdata_q <= 6'd0;
         size_q  <= 4'd0;
         eat_q   <= 1'b0;
         busy_q  <= 1'b0;
         won_q   <= 1'b0;
         lost_q  <= 1'b0;
         fin_q   <= 1'b0;
         nh_q    <= 6'd0;
         grow_q  <= 1'b0;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         eat_q   <= eat_d;
         busy_q  <= busy_d;
         won_q   <= won_d;
         lost_q  <= lost_d;
         fin_q   <= fin_d;
         nh_q    <= nh_d;
         grow_q  <= grow_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         cap_q   <= cap_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign size      = size_q;
   assign eat       = eat_q;
   assign busy      = busy_q;
   assign won       = won_q;
   assign lost      = lost_q;
   assign finished  = fin_q;
   assign db_state  = state_q;

endmodule

// File: tb/tb_snake_move_controller.sv
// Directed bench for snake_move_controller with a behavioural body RAM (one-cycle read latency).
// Positions are written in octal: 6'oRC is row R, column C.
// Each test task drives its scenario and compares outputs/RAM against hand-computed values.
module tb_snake_move_controller;
   localparam int MAX_SIZE = 8;
   localparam int BUSY_MAX = 3 * MAX_SIZE + 4;

   logic       clock = 1'b0;
   logic       restart_n, start, pause, tick;
   logic [1:0] dir;
   logic [5:0] apple_pos, mem_rdata;
   logic [3:0] mem_addr, size;
   logic       mem_we, eat, busy, won, lost, finished;
   logic [5:0] mem_wdata;
   logic [4:0] db_state;

   logic [5:0] ram [0:15];
   int wr_count = 0, eat_count = 0, addr_viol = 0;
   int n_checks = 0, n_fail = 0;

   always #5 clock = ~clock;

   snake_move_controller #(.MAX_SIZE(MAX_SIZE), .INIT_SIZE(2)) dut (
      .clock(clock), .restart_n(restart_n), .start(start), .pause(pause), .tick(tick),
      .dir(dir), .apple_pos(apple_pos), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .size(size), .eat(eat), .busy(busy),
      .won(won), .lost(lost), .finished(finished), .db_state(db_state)
   );

   // Body RAM model plus write/eat/address monitors
   always @(posedge clock) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
      if (eat) eat_count <= eat_count + 1;
      if (mem_addr > 4'(MAX_SIZE - 1)) addr_viol <= addr_viol + 1;
      mem_rdata <= ram[mem_addr];
   end

   task automatic do_start();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      @(negedge clock);
      @(negedge clock);
   endtask

   // One tick-driven move; dir/apple are scrambled after CALC. n = cycles until busy low (busy cycles = n-1).
   task automatic do_move(input logic [1:0] d, input logic [5:0] a, output int n);
      @(negedge clock); dir = d; apple_pos = a; tick = 1'b1;
      @(negedge clock); tick = 1'b0;
      @(negedge clock); dir = ~d; apple_pos = ~a;
      n = 2;
      while (busy && n < 60) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic test_reset();
      restart_n = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; dir = 2'b00; apple_pos = 6'o55;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({size, eat, busy, won, lost, finished, db_state, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: size=%0d eat=%0b busy=%0b won=%0b lost=%0b fin=%0b state=%0d we=%0b addr=%0d wdata=%0d, all required 0",
                  size, eat, busy, won, lost, finished, db_state, mem_we, mem_addr, mem_wdata);
      end
      restart_n = 1'b1;
   endtask

   task automatic test_init();
      @(negedge clock); start = 1'b1; tick = 1'b1;
      @(negedge clock); start = 1'b0; tick = 1'b0;
      n_checks++;
      if ({db_state, mem_we, mem_addr, mem_wdata} !== {5'd1, 1'b1, 4'd0, 6'o22}) begin
         n_fail++;
         $display("FAIL init_cycle1: state=%0d we=%0b addr=%0d wdata=%o, required 1 1 0 22", db_state, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clock);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd1, 6'o21}) begin
         n_fail++;
         $display("FAIL init_cycle2: we=%0b addr=%0d wdata=%o, required 1 1 21", mem_we, mem_addr, mem_wdata);
      end
      @(negedge clock);
      n_checks++;
      if ({db_state, size, busy, ram[0], ram[1]} !== {5'd2, 4'd2, 1'b0, 6'o22, 6'o21}) begin
         n_fail++;
         $display("FAIL init_done: state=%0d size=%0d busy=%0b ram0=%o ram1=%o, required 2 2 0 22 21", db_state, size, busy, ram[0], ram[1]);
      end
      @(negedge clock);
      n_checks++;
      if ({db_state, busy} !== {5'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL start_tick_dropped: state=%0d busy=%0b, required 2 0", db_state, busy);
      end
   endtask

   task automatic test_move();
      int n, w0, e0;
      w0 = wr_count; e0 = eat_count;
      do_move(2'b01, 6'o55, n);
      n_checks++;
      if ({ram[0], ram[1], size} !== {6'o23, 6'o22, 4'd2} || eat_count != e0 || wr_count - w0 != 2) begin
         n_fail++;
         $display("FAIL move_right: ram0=%o ram1=%o size=%0d eats=%0d writes=%0d, required 23 22 2 0 2",
                  ram[0], ram[1], size, eat_count - e0, wr_count - w0);
      end
      n_checks++;
      if (n - 1 > BUSY_MAX || db_state !== 5'd2) begin
         n_fail++;
         $display("FAIL move_busy: busy cycles=%0d state=%0d, required <=%0d and state 2", n - 1, db_state, BUSY_MAX);
      end
   endtask

   task automatic test_eat();
      int n, w0, e0;
      w0 = wr_count; e0 = eat_count;
      do_move(2'b01, 6'o24, n);
      n_checks++;
      if ({ram[0], ram[1], ram[2], size} !== {6'o24, 6'o23, 6'o22, 4'd3} || wr_count - w0 != 3) begin
         n_fail++;
         $display("FAIL eat_body: ram0=%o ram1=%o ram2=%o size=%0d writes=%0d, required 24 23 22 3 3",
                  ram[0], ram[1], ram[2], size, wr_count - w0);
      end
      n_checks++;
      if (eat_count - e0 != 1) begin
         n_fail++;
         $display("FAIL eat_pulse: eat cycles=%0d, required 1", eat_count - e0);
      end
   endtask

   task automatic test_pause();
      int n, w0;
      w0 = wr_count;
      @(negedge clock); pause = 1'b1; tick = 1'b1;
      @(negedge clock); tick = 1'b0;
      repeat (2) begin
         @(negedge clock); tick = 1'b1;
         @(negedge clock); tick = 1'b0;
      end
      @(negedge clock);
      n_checks++;
      if ({db_state, busy} !== {5'd3, 1'b0} || wr_count != w0) begin
         n_fail++;
         $display("FAIL pause_hold: state=%0d busy=%0b writes=%0d, required 3 0 0", db_state, busy, wr_count - w0);
      end
      pause = 1'b0;
      @(negedge clock);
      n_checks++;
      if (db_state !== 5'd2) begin
         n_fail++;
         $display("FAIL pause_release: state=%0d, required 2", db_state);
      end
      do_move(2'b10, 6'o55, n);
      n_checks++;
      if ({ram[0], ram[1], ram[2], size} !== {6'o34, 6'o24, 6'o23, 4'd3} || wr_count - w0 != 3) begin
         n_fail++;
         $display("FAIL pause_then_move: ram0=%o ram1=%o ram2=%o size=%0d writes=%0d, required 34 24 23 3 3",
                  ram[0], ram[1], ram[2], size, wr_count - w0);
      end
   endtask

   task automatic test_tail_follow();
      int n;
      do_move(2'b11, 6'o33, n);
      do_move(2'b00, 6'o55, n);
      n_checks++;
      if ({lost, ram[0], ram[1], ram[2], ram[3], size} !== {1'b0, 6'o23, 6'o33, 6'o34, 6'o24, 4'd4}) begin
         n_fail++;
         $display("FAIL tail_follow: lost=%0b body=%o %o %o %o size=%0d, required 0 23 33 34 24 4",
                  lost, ram[0], ram[1], ram[2], ram[3], size);
      end
   endtask

   task automatic test_grow_into_tail();
      int n, w0, e0;
      w0 = wr_count; e0 = eat_count;
      do_move(2'b01, 6'o24, n);
      n_checks++;
      if ({lost, finished, won, db_state, size} !== {1'b1, 1'b1, 1'b0, 5'd9, 4'd4} || wr_count != w0 || eat_count != e0) begin
         n_fail++;
         $display("FAIL self_collision: lost=%0b fin=%0b won=%0b state=%0d size=%0d writes=%0d eats=%0d, required 1 1 0 9 4 0 0",
                  lost, finished, won, db_state, size, wr_count - w0, eat_count - e0);
      end
   endtask

   task automatic test_restart_game();
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      n_checks++;
      if ({lost, finished, db_state} !== {1'b0, 1'b0, 5'd1}) begin
         n_fail++;
         $display("FAIL lost_clears: lost=%0b fin=%0b state=%0d, required 0 0 1", lost, finished, db_state);
      end
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if ({ram[0], ram[1], size, db_state} !== {6'o22, 6'o21, 4'd2, 5'd2}) begin
         n_fail++;
         $display("FAIL reinit: ram0=%o ram1=%o size=%0d state=%0d, required 22 21 2 2", ram[0], ram[1], size, db_state);
      end
   endtask

   task automatic test_wall();
      int n, w0;
      repeat (3) do_move(2'b01, 6'o55, n);
      n_checks++;
      if ({ram[0], lost} !== {6'o25, 1'b0}) begin
         n_fail++;
         $display("FAIL wall_approach: ram0=%o lost=%0b, required 25 0", ram[0], lost);
      end
      w0 = wr_count;
      do_move(2'b01, 6'o55, n);
      n_checks++;
      if ({lost, finished, db_state} !== {1'b1, 1'b1, 5'd9} || wr_count != w0 || n - 1 > BUSY_MAX) begin
         n_fail++;
         $display("FAIL wall_hit: lost=%0b fin=%0b state=%0d writes=%0d busy=%0d, required 1 1 9 0 <=%0d",
                  lost, finished, db_state, wr_count - w0, n - 1, BUSY_MAX);
      end
   endtask

   task automatic test_restart_mid_shift();
      int n;
      do_start();
      @(negedge clock); dir = 2'b01; apple_pos = 6'o55; tick = 1'b1;
      @(negedge clock); tick = 1'b0;
      n = 0;
      while (db_state !== 5'd6 && n < 40) begin
         @(negedge clock);
         n++;
      end
      n_checks++;
      if (db_state !== 5'd6) begin
         n_fail++;
         $display("FAIL reach_shift: state=%0d after %0d cycles, required 6", db_state, n);
      end
      restart_n = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({db_state, mem_we, size, busy} !== {5'd0, 1'b0, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL restart_mid_shift: state=%0d we=%0b size=%0d busy=%0b, required 0 0 0 0", db_state, mem_we, size, busy);
      end
      restart_n = 1'b1;
   endtask

   task automatic test_win();
      logic [1:0] wd [6];
      logic [5:0] wa [6];
      int n, e0;
      wd = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
      wa = '{6'o23, 6'o24, 6'o25, 6'o35, 6'o45, 6'o55};
      do_start();
      for (int i = 0; i < 6; i++) begin
         e0 = eat_count;
         do_move(wd[i], wa[i], n);
         n_checks++;
         if (size !== 4'(3 + i) || eat_count - e0 != 1 || n - 1 > BUSY_MAX || lost !== 1'b0) begin
            n_fail++;
            $display("FAIL grow_step%0d: size=%0d eats=%0d busy=%0d lost=%0b, required %0d 1 <=%0d 0",
                     i, size, eat_count - e0, n - 1, lost, 3 + i, BUSY_MAX);
         end
      end
      n_checks++;
      if ({won, lost, finished, db_state, ram[0], ram[7]} !== {1'b1, 1'b0, 1'b1, 5'd8, 6'o55, 6'o21}) begin
         n_fail++;
         $display("FAIL win: won=%0b lost=%0b fin=%0b state=%0d ram0=%o ram7=%o, required 1 0 1 8 55 21",
                  won, lost, finished, db_state, ram[0], ram[7]);
      end
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0; start = 1'b1;
      @(negedge clock); start = 1'b0;
      n_checks++;
      if ({won, finished, db_state} !== {1'b0, 1'b0, 5'd1}) begin
         n_fail++;
         $display("FAIL won_clears: won=%0b fin=%0b state=%0d, required 0 0 1", won, finished, db_state);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_move();
      test_eat();
      test_pause();
      test_tail_follow();
      test_grow_into_tail();
      test_restart_game();
      test_wall();
      test_restart_mid_shift();
      test_win();
      repeat (3) @(negedge clock);
      n_checks++;
      if (addr_viol != 0) begin
         n_fail++;
         $display("FAIL addr_range: %0d cycles with mem_addr above %0d, required 0", addr_viol, MAX_SIZE - 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
